// File: rtl/pipeline_stall_controller_pkg.sv
// Shared types and defaults for the pipeline stall controller.
// Holds the FSM state enum, default MDU/memory timing constants and a width helper.
package pipeline_stall_controller_pkg;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MDU_BUSY = 1'b1
  } state_t;

  localparam int DEF_MDU_LATENCY = 4;
  localparam int DEF_MEM_TIMEOUT = 255;

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int cnt_width(input int max_val);
    return (max_val > 1) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/pipeline_stall_controller_if.sv
// Hazard inputs and pipeline-control outputs of the stall controller.
// The master side is the hazard/datapath logic; the slave side is the controller.
interface pipeline_stall_controller_if;

  logic load_use_hazard;
  logic mdu_start;
  logic branch_taken;
  logic mem_wait;
  logic PC_write;
  logic IF_ID_write;
  logic ID_EX_bubble;
  logic IF_ID_flush;
  logic pipe_freeze;
  logic mdu_busy;
  logic mem_timeout;

  modport master (
    output load_use_hazard, mdu_start, branch_taken, mem_wait,
    input  PC_write, IF_ID_write, ID_EX_bubble, IF_ID_flush,
    input  pipe_freeze, mdu_busy, mem_timeout
  );

  modport slave (
    input  load_use_hazard, mdu_start, branch_taken, mem_wait,
    output PC_write, IF_ID_write, ID_EX_bubble, IF_ID_flush,
    output pipe_freeze, mdu_busy, mem_timeout
  );

endinterface

// File: rtl/pipeline_stall_controller_mdu_occupancy_counter.sv
// Down-counter tracking remaining multiply/divide occupancy cycles.
// zero flags that the current decrement brings the count to zero.
module mdu_occupancy_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  assign zero = dec && !load && (count_d == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Five-stage pipeline stall/flush/freeze controller with MDU occupancy and memory timeout.
// Define STALL_PERF_COUNTER_EN to add the 32-bit stall_cycles performance counter.
module pipeline_stall_controller
  import pipeline_stall_controller_pkg::*;
#(
  parameter int MDU_LATENCY = DEF_MDU_LATENCY,
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT
) (
  input  logic                          clk,
  input  logic                          reset_n,
  pipeline_stall_controller_if.slave    bus
`ifdef STALL_PERF_COUNTER_EN
  ,
  output logic [31:0]                   stall_cycles
`endif
);

  localparam int CNT_W  = cnt_width(MDU_LATENCY - 1);
  localparam int WAIT_W = cnt_width(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0]  MDU_LOAD    = CNT_W'(MDU_LATENCY - 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_VAL = WAIT_W'(MEM_TIMEOUT);

  state_t              state_q;
  state_t              state_d;
  logic                mdu_load;
  logic                mdu_dec;
  logic                mdu_zero;
  logic [WAIT_W-1:0]   wait_cnt_q;
  logic [WAIT_W-1:0]   wait_cnt_d;
  logic                timeout_q;
  logic                timeout_d;

  function automatic logic [WAIT_W-1:0] sat_inc(input logic [WAIT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  mdu_occupancy_counter #(
    .W (CNT_W)
  ) u_mdu_cnt (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (mdu_load),
    .load_value (MDU_LOAD),
    .dec        (mdu_dec),
    .zero       (mdu_zero)
  );

  // Priority: mem_wait > branch_taken > MDU_BUSY > load_use_hazard > mdu_start
  always_comb begin
    state_d          = state_q;
    mdu_load         = 1'b0;
    mdu_dec          = (state_q == MDU_BUSY);
    bus.PC_write     = 1'b1;
    bus.IF_ID_write  = 1'b1;
    bus.ID_EX_bubble = 1'b0;
    bus.IF_ID_flush  = 1'b0;
    bus.pipe_freeze  = 1'b0;
    if (bus.mem_wait) begin
      bus.pipe_freeze  = 1'b1;
      bus.PC_write     = 1'b0;
      bus.IF_ID_write  = 1'b0;
    end else if (bus.branch_taken) begin
      bus.IF_ID_flush  = 1'b1;
      bus.ID_EX_bubble = 1'b1;
    end else if (state_q == MDU_BUSY) begin
      bus.PC_write     = 1'b0;
      bus.IF_ID_write  = 1'b0;
      bus.ID_EX_bubble = 1'b1;
    end else if (bus.load_use_hazard) begin
      bus.PC_write     = 1'b0;
      bus.IF_ID_write  = 1'b0;
      bus.ID_EX_bubble = 1'b1;
    end else if (bus.mdu_start) begin
      state_d  = MDU_BUSY;
      mdu_load = 1'b1;
    end
    // Occupancy runs out regardless of freezes or flushes.
    if ((state_q == MDU_BUSY) && mdu_zero) begin
      state_d = RUN;
    end
  end

  assign bus.mdu_busy = (state_q == MDU_BUSY);

  // Wait count includes the current cycle so the flag rises on the N-th wait cycle.
  assign wait_cnt_d      = bus.mem_wait ? sat_inc(wait_cnt_q) : '0;
  assign timeout_d       = timeout_q | (bus.mem_wait && (wait_cnt_d >= TIMEOUT_VAL));
  assign bus.mem_timeout = timeout_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

`ifdef STALL_PERF_COUNTER_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
    end else if (!bus.PC_write && !(&stall_cnt_q)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed scoreboard bench for pipeline_stall_controller (MDU_LATENCY=4, MEM_TIMEOUT=255).
// Output vector order: PC_write, IF_ID_write, ID_EX_bubble, IF_ID_flush, pipe_freeze, mdu_busy, mem_timeout.
module tb_pipeline_stall_controller;

  localparam logic [6:0] NORM    = 7'b1100000;
  localparam logic [6:0] STALL   = 7'b0010000;
  localparam logic [6:0] BUSY    = 7'b0010010;
  localparam logic [6:0] FLUSH   = 7'b1111000;
  localparam logic [6:0] FLUSH_B = 7'b1111010;
  localparam logic [6:0] FRZ     = 7'b0000100;
  localparam logic [6:0] FRZ_B   = 7'b0000110;
  localparam logic [6:0] TO      = 7'b0000001;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;
  int   exp_stalls;
  logic [6:0] exp_q[$];
  string      tag_q[$];

  pipeline_stall_controller_if bus ();

`ifdef STALL_PERF_COUNTER_EN
  logic [31:0] stall_cycles;
`endif

  pipeline_stall_controller #(
    .MDU_LATENCY (4),
    .MEM_TIMEOUT (255)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
`ifdef STALL_PERF_COUNTER_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check();
    logic [6:0] got;
    logic [6:0] exp;
    string      tag;
    exp = exp_q.pop_front();
    tag = tag_q.pop_front();
    got = {bus.PC_write, bus.IF_ID_write, bus.ID_EX_bubble, bus.IF_ID_flush,
           bus.pipe_freeze, bus.mdu_busy, bus.mem_timeout};
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
    if (!exp[6]) exp_stalls++;
  endtask

  // Drive one cycle of inputs just after the rising edge, check on the falling edge.
  task automatic step(input logic lu, input logic ms, input logic br, input logic mw,
                      input logic [6:0] exp, input string tag);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    bus.load_use_hazard = lu;
    bus.mdu_start       = ms;
    bus.branch_taken    = br;
    bus.mem_wait        = mw;
    @(negedge clk);
    check();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    exp_stalls = 0;
    reset_n    = 1'b0;
    bus.load_use_hazard = 1'b0;
    bus.mdu_start       = 1'b0;
    bus.branch_taken    = 1'b0;
    bus.mem_wait        = 1'b0;

    repeat (2) @(posedge clk);
    exp_q.push_back(NORM);
    tag_q.push_back("reset_state");
    @(negedge clk);
    check();
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    step(0, 0, 0, 0, NORM,  "first_after_reset");
    step(1, 0, 0, 0, STALL, "load_use");
    step(0, 0, 0, 0, NORM,  "load_use_released");

    step(0, 1, 0, 0, NORM, "mdu_issue");
    step(0, 0, 0, 0, BUSY, "mdu_busy1");
    step(0, 0, 0, 0, BUSY, "mdu_busy2");
    step(0, 0, 0, 0, BUSY, "mdu_busy3");
    step(0, 0, 0, 0, NORM, "mdu_done");

    step(1, 0, 1, 0, FLUSH, "branch_over_load_use");
    step(0, 0, 0, 0, NORM,  "after_branch");

    step(1, 1, 0, 0, STALL, "mdu_with_load_use");
    step(0, 1, 0, 0, NORM,  "mdu_resampled_issue");
    step(0, 0, 0, 0, BUSY,  "resampled_busy1");
    step(0, 0, 0, 0, BUSY,  "resampled_busy2");
    step(0, 0, 0, 0, BUSY,  "resampled_busy3");
    step(0, 0, 0, 0, NORM,  "resampled_done");

    step(0, 1, 0, 0, NORM,  "mdu_issue_memwait");
    step(0, 0, 0, 1, FRZ_B, "busy_memwait1");
    step(0, 0, 0, 1, FRZ_B, "busy_memwait2");
    step(0, 0, 0, 0, BUSY,  "busy_after_memwait");
    step(0, 0, 0, 0, NORM,  "memwait_busy_exit");

    step(0, 1, 0, 0, NORM,    "mdu_issue_branch");
    step(0, 0, 1, 0, FLUSH_B, "busy_branch");
    step(0, 0, 0, 0, BUSY,    "busy_after_branch2");
    step(0, 0, 0, 0, BUSY,    "busy_after_branch3");
    step(0, 0, 0, 0, NORM,    "branch_busy_exit");

    step(0, 0, 1, 1, FRZ,  "memwait_over_branch");
    step(0, 1, 0, 1, FRZ,  "memwait_blocks_mdu");
    step(0, 0, 0, 0, NORM, "no_busy_after_frozen_mdu");
    step(0, 1, 1, 0, FLUSH, "branch_blocks_mdu");
    step(0, 0, 0, 0, NORM,  "no_busy_after_branch_mdu");

    for (int i = 0; i < 200; i++) step(0, 0, 0, 1, FRZ, "wait_run_short");
    step(0, 0, 0, 0, NORM, "wait_cleared");
    for (int i = 0; i < 100; i++) step(0, 0, 0, 1, FRZ, "wait_after_clear");
    step(0, 0, 0, 0, NORM, "no_timeout_nonconsecutive");

    for (int i = 1; i < 255; i++) step(0, 0, 0, 1, FRZ, "wait_below_timeout");
    step(0, 0, 0, 1, FRZ | TO,  "timeout_at_255");
    step(0, 0, 0, 1, FRZ | TO,  "timeout_held_waiting");
    step(0, 0, 0, 0, NORM | TO, "timeout_sticky");
    step(1, 0, 0, 0, STALL | TO, "timeout_sticky_stall");

    step(0, 1, 0, 0, NORM | TO, "mdu_issue_pre_reset");
    step(0, 0, 0, 0, BUSY | TO, "busy1_pre_reset");
    exp_q.push_back(NORM);
    tag_q.push_back("reset_mid_busy");
    reset_n = 1'b0;
    @(negedge clk);
    check();
    exp_stalls = 0;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    step(0, 0, 0, 0, NORM, "run_after_reset");
    step(0, 0, 0, 0, NORM, "run_after_reset2");
    step(1, 0, 0, 0, STALL, "load_use_after_reset");
    step(0, 0, 0, 0, NORM,  "final_idle");

`ifdef STALL_PERF_COUNTER_EN
    total++;
    assert (stall_cycles === 32'(exp_stalls)) else begin
      bad++;
      $error("FAIL stall_cycles observed=%0d expected=%0d", stall_cycles, exp_stalls);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_controller.md
PIPELINE_STALL_CONTROLLER -- requirements
Module: pipeline_stall_controller

Interface
REQ-001 SHALL have parameter MDU_LATENCY, default 4, range 2-16: multiply/divide occupancy in cycles.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 255: mem_wait cycles before timeout is flagged.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port load_use_hazard, input, 1: load-use hazard detected for the instruction in ID.
REQ-006 SHALL have port mdu_start, input, 1: instruction in ID issues a multiply/divide.
REQ-007 SHALL have port branch_taken, input, 1: branch or jump in EX resolved taken.
REQ-008 SHALL have port mem_wait, input, 1: data memory not ready; the whole pipe must freeze.
REQ-009 SHALL have outputs PC_write, IF_ID_write, 1 bit each: 1 = register updates this cycle.
REQ-010 SHALL have outputs ID_EX_bubble, IF_ID_flush, 1 bit each: 1 = insert NOP / clear IF/ID.
REQ-011 SHALL have output pipe_freeze, 1: 1 = ID/EX, EX/MEM and MEM/WB hold.
REQ-012 SHALL have output mdu_busy, 1: state is MDU_BUSY.
REQ-013 SHALL have output mem_timeout, 1: sticky timeout flag.

Function
REQ-014 SHALL implement FSM states RUN and MDU_BUSY; outputs are combinational from state and current inputs.
REQ-015 Priority SHALL be mem_wait > branch_taken > MDU_BUSY > load_use_hazard > mdu_start.
REQ-016 mem_wait=1 SHALL drive pipe_freeze=1, PC_write=0, IF_ID_write=0, ID_EX_bubble=0, IF_ID_flush=0.
REQ-017 branch_taken=1 without mem_wait SHALL drive PC_write=1, IF_ID_flush=1, ID_EX_bubble=1, all in the same cycle.
REQ-018 In RUN, load_use_hazard=1 alone SHALL drive PC_write=0, IF_ID_write=0, ID_EX_bubble=1 for exactly that cycle, with no state change.
REQ-019 In RUN, mdu_start=1 without a higher-priority event SHALL transition to MDU_BUSY and load the counter with MDU_LATENCY-1; that cycle's outputs are normal (issue proceeds).
REQ-020 In MDU_BUSY, outputs SHALL be PC_write=0, IF_ID_write=0, ID_EX_bubble=1; the counter decrements every cycle, including during mem_wait.
REQ-021 MDU_BUSY SHALL return to RUN on the cycle after the counter reads 0; total stall = MDU_LATENCY-1 cycles.
REQ-022 branch_taken during MDU_BUSY SHALL flush per REQ-017 without leaving MDU_BUSY or altering the counter.
REQ-023 mdu_start and load_use_hazard together SHALL apply the load-use stall only; mdu_start is re-sampled next cycle.
REQ-024 Wait counter SHALL count consecutive mem_wait cycles, clear when mem_wait=0, and saturate.
REQ-025 mem_timeout SHALL set when the wait counter reaches MEM_TIMEOUT and hold until reset.
REQ-026 With no event in RUN, outputs SHALL be PC_write=1, IF_ID_write=1, all others 0.

Reset
REQ-027 reset_n=0 SHALL immediately force state RUN, both counters 0, mem_timeout 0 and any stall counter 0, including mid-MDU_BUSY.
REQ-028 First edge after reset release SHALL behave as RUN with no pending events.

Configuration
REQ-029 With STALL_PERF_COUNTER_EN defined, SHALL add 32-bit output stall_cycles, counting cycles with PC_write=0, saturating at 0xFFFFFFFF.
REQ-030 Without STALL_PERF_COUNTER_EN, stall_cycles and its counter SHALL be absent, with no other behavioural change.

Structure
REQ-031 FSM state enum and default MDU_LATENCY/MEM_TIMEOUT constants SHALL live in the shared pipeline package.
REQ-032 The down-counter SHALL be a sub-module, mdu_occupancy_counter (load, decrement, zero flag).

Verification
REQ-033 load_use_hazard=1 for 1 cycle in RUN -> PC_write=0, IF_ID_write=0, ID_EX_bubble=1 that cycle only.
REQ-034 mdu_start=1, MDU_LATENCY=4 -> mdu_busy=1 for 3 cycles, then PC_write=1.
REQ-035 branch_taken=1 with load_use_hazard=1 -> PC_write=1, IF_ID_flush=1, ID_EX_bubble=1.
REQ-036 mem_wait=1 during MDU_BUSY for 2 cycles -> pipe_freeze=1; MDU_BUSY still exits after 3 total cycles.
REQ-037 mem_wait=1 for 255 cycles -> mem_timeout=1 on the 255th cycle and held after mem_wait drops; cleared by reset_n=0.
REQ-038 reset_n=0 in the 2nd MDU_BUSY cycle -> immediate RUN, mdu_busy=0, PC_write=1.
